// File: rtl/fetch_queue_unit_pkg.sv
// Shared definitions for the fetch queue unit: queue entry layout, fetch FSM
// states and RV32 JAL decode helpers.
package fetch_queue_unit_pkg;

  localparam logic [6:0] OpcJal = 7'b1101111;

  // One queued instruction: the raw word, its fetch PC and the taken flag.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jump;
  } fq_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFlush
  } fetch_state_e;

  // J-type immediate: imm[20|10:1|11|19:12] at inst[31|30:21|20|19:12], bit 0 = 0.
  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_queue.sv
// Circular instruction FIFO for the fetch unit.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push_i      write wdata_i at the tail
//   pop_i       advance the head (caller guarantees non-empty)
//   clear_i     empty the queue; overrides push and pop
//   wdata_i     entry to push
//   count_o     number of valid entries (0..Depth)
//   head_o      entry at the head, valid when count_o != 0
module fetch_queue
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  fq_entry_t                wdata_i,
  output logic [$clog2(Depth):0]   count_o,
  output fq_entry_t                head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;
  fq_entry_t       mem_q [Depth];
  fq_entry_t       mem_d [Depth];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q] = wdata_i;
        tail_d        = tail_q + PtrW'(1);
      end
      if (pop_i) begin
        head_d = head_q + PtrW'(1);
      end
      // Push and pop together leave the count unchanged, even when full.
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity is carried by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit with a decoupled instruction queue between the
// i-cache and the dispatcher. Keeps the fetch PC, follows JAL and predictor
// redirects, prefetches up to QUEUE_DEPTH instructions and flushes on ROB reset.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rdy                          global enable; low freezes all state
//   cache_valid, cache_inst      i-cache response for the outstanding request
//   cache_pc, fetch_enable       i-cache request address / request active
//   predict_pc, predict_inst     outstanding request PC and returned word
//   suggest_jump, suggest_pc     predictor taken flag and next PC
//   should_reset, reset_pc       ROB flush and redirect target
//   out_valid/out_ready          dispatcher handshake on the queue head
//   out_inst, out_pc, out_jump   queue head contents
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        cache_valid,
  input  logic [31:0] cache_inst,
  output logic [31:0] cache_pc,
  output logic        fetch_enable,
  output logic [31:0] predict_pc,
  output logic [31:0] predict_inst,
  input  logic        suggest_jump,
  input  logic [31:0] suggest_pc,
  input  logic        should_reset,
  input  logic [31:0] reset_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_jump
);

  localparam int unsigned CntW     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(QUEUE_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cache_pc_q, cache_pc_d;
  logic         fetch_enable_q, fetch_enable_d;

  logic            q_push, q_pop, q_clear;
  logic [CntW-1:0] q_count;
  logic [CntW-1:0] count_after_pop;
  fq_entry_t       q_head;
  fq_entry_t       q_wdata;
  logic            idle_free, busy_free;
  logic            is_jal;
  logic [31:0]     next_pc;
  logic            next_jump;

  assign out_valid = (q_count != '0);
  assign q_pop     = rdy & out_valid & out_ready & ~should_reset;

  // Slot accounting includes this cycle's pop so a full queue being drained
  // can issue the next request without a bubble.
  assign count_after_pop = q_count - CntW'(q_pop);
  assign idle_free       = count_after_pop < DepthCnt;
  assign busy_free       = (count_after_pop + CntW'(1)) < DepthCnt;

  assign is_jal    = (cache_inst[6:0] == OpcJal);
  assign next_pc   = is_jal ? (cache_pc_q + j_imm(cache_inst)) : suggest_pc;
  assign next_jump = is_jal | suggest_jump;

  assign q_wdata = '{inst: cache_inst, pc: cache_pc_q, jump: next_jump};

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cache_pc_d     = cache_pc_q;
    fetch_enable_d = fetch_enable_q;
    q_push         = 1'b0;
    q_clear        = 1'b0;
    if (rdy) begin
      if (should_reset) begin
        // Any response arriving now belongs to the squashed path.
        pc_d           = reset_pc;
        q_clear        = 1'b1;
        fetch_enable_d = 1'b0;
        state_d        = StFlush;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (idle_free) begin
              fetch_enable_d = 1'b1;
              cache_pc_d     = pc_q;
              state_d        = StBusy;
            end else begin
              fetch_enable_d = 1'b0;
            end
          end
          StBusy: begin
            if (cache_valid) begin
              q_push = 1'b1;
              pc_d   = next_pc;
              if (busy_free) begin
                cache_pc_d = next_pc;
              end else begin
                fetch_enable_d = 1'b0;
                state_d        = StIdle;
              end
            end
          end
          StFlush: begin
            fetch_enable_d = 1'b1;
            cache_pc_d     = pc_q;
            state_d        = StBusy;
          end
          default: begin
            fetch_enable_d = 1'b0;
            state_d        = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pc_q           <= RESET_PC;
      cache_pc_q     <= '0;
      fetch_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      cache_pc_q     <= cache_pc_d;
      fetch_enable_q <= fetch_enable_d;
    end
  end

  fetch_queue #(
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .clear_i (q_clear),
    .wdata_i (q_wdata),
    .count_o (q_count),
    .head_o  (q_head)
  );

  assign cache_pc     = cache_pc_q;
  assign fetch_enable = fetch_enable_q;
  assign predict_pc   = cache_pc_q;
  assign predict_inst = cache_inst;
  assign out_inst     = q_head.inst;
  assign out_pc       = q_head.pc;
  assign out_jump     = q_head.jump;

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  localparam int unsigned Depth   = 4;
  localparam logic [31:0] ResetPc = 32'h0;
  localparam logic [31:0] Addi    = 32'h00100093;
  localparam logic [31:0] JalP20  = 32'h0200006F;  // jal x0, +0x20

  logic        clk = 1'b0;
  logic        rst, rdy, cache_valid, suggest_jump, should_reset, out_ready;
  logic [31:0] cache_inst, suggest_pc, reset_pc;
  logic [31:0] cache_pc, predict_pc, predict_inst, out_inst, out_pc;
  logic        fetch_enable, out_valid, out_jump;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jump;
  } ent_t;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .QUEUE_DEPTH (Depth),
    .RESET_PC    (ResetPc)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .cache_valid  (cache_valid),
    .cache_inst   (cache_inst),
    .cache_pc     (cache_pc),
    .fetch_enable (fetch_enable),
    .predict_pc   (predict_pc),
    .predict_inst (predict_inst),
    .suggest_jump (suggest_jump),
    .suggest_pc   (suggest_pc),
    .should_reset (should_reset),
    .reset_pc     (reset_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_jump     (out_jump)
  );

  // Signed J-immediate computed arithmetically from the field weights.
  function automatic logic [31:0] jimm_model(input logic [31:0] inst);
    int v;
    v = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096;
    if (inst[31]) v = v - (1 << 20);
    return 32'(v);
  endfunction

  // Stimulus only: holds reset for two edges, leaves the bench at a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; cache_valid = 1'b0; cache_inst = '0;
    suggest_jump = 1'b0; suggest_pc = '0; should_reset = 1'b0;
    reset_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (fetch_enable !== 1'b0) begin n_fail++;
      $display("FAIL reset_fetch_enable got=%b exp=0", fetch_enable); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (cache_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_cache_pc got=%h exp=0", cache_pc); end
    @(negedge clk);
    n_checks++; if (fetch_enable !== 1'b1 || cache_pc !== ResetPc) begin n_fail++;
      $display("FAIL reset_first_req fe=%b pc=%h exp fe=1 pc=%h", fetch_enable, cache_pc,
               ResetPc); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    @(negedge clk);
    cache_valid = 1'b1; cache_inst = Addi; suggest_pc = 32'h4; suggest_jump = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL first_no_bypass got=%b exp=0", out_valid); end
    @(negedge clk);
    cache_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== Addi ||
                    out_jump !== 1'b0) begin n_fail++;
      $display("FAIL first_head v=%b pc=%h inst=%h j=%b exp v=1 pc=0 inst=%h j=0",
               out_valid, out_pc, out_inst, out_jump, Addi); end
    n_checks++; if (cache_pc !== 32'h4 || fetch_enable !== 1'b1) begin n_fail++;
      $display("FAIL first_next_req pc=%h fe=%b exp pc=4 fe=1", cache_pc, fetch_enable); end
  endtask

  task automatic test_jal();
    do_reset();
    @(negedge clk);
    cache_valid = 1'b1; cache_inst = Addi; suggest_pc = 32'h10;
    @(negedge clk);
    n_checks++; if (cache_pc !== 32'h10) begin n_fail++;
      $display("FAIL jal_req_pc got=%h exp=10", cache_pc); end
    cache_inst = JalP20; suggest_pc = 32'h14; out_ready = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (cache_pc !== 32'h30) begin n_fail++;
      $display("FAIL jal_target got=%h exp=30", cache_pc); end
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_jump !== 1'b1 ||
                    out_inst !== JalP20) begin n_fail++;
      $display("FAIL jal_head v=%b pc=%h j=%b inst=%h exp v=1 pc=10 j=1 inst=%h",
               out_valid, out_pc, out_jump, out_inst, JalP20); end
  endtask

  // Leaves the queue full ({4,8,c,10}) and the unit idle for test_full_push_pop.
  task automatic test_full();
    int pushes = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cache_valid = fetch_enable; cache_inst = Addi;
      suggest_pc = 32'((pushes + 1) * 4);
      if (fetch_enable) pushes++;
    end
    cache_valid = 1'b0;
    n_checks++; if (pushes != 4) begin n_fail++;
      $display("FAIL full_push_count got=%0d exp=4", pushes); end
    n_checks++; if (fetch_enable !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL full_stall fe=%b v=%b pc=%h exp fe=0 v=1 pc=0", fetch_enable, out_valid,
               out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (fetch_enable !== 1'b1 || cache_pc !== 32'h10 || out_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL full_one_pop fe=%b req=%h head=%h exp fe=1 req=10 head=4", fetch_enable,
               cache_pc, out_pc); end
    cache_valid = 1'b1; cache_inst = Addi; suggest_pc = 32'h14;
    @(negedge clk);
    cache_valid = 1'b0;
    n_checks++; if (fetch_enable !== 1'b0 || out_pc !== 32'h4) begin n_fail++;
      $display("FAIL full_refill fe=%b head=%h exp fe=0 head=4", fetch_enable, out_pc); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_head = 32'h8;
    logic [31:0] exp_req  = 32'h14;
    int pops = 0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (fetch_enable !== 1'b1 || cache_pc !== exp_req || out_valid !== 1'b1 ||
                      out_pc !== exp_head) begin n_fail++;
        $display("FAIL pushpop_step%0d fe=%b req=%h v=%b head=%h exp fe=1 req=%h head=%h", i,
                 fetch_enable, cache_pc, out_valid, out_pc, exp_req, exp_head); end
      cache_valid = 1'b1; cache_inst = Addi; suggest_pc = exp_req + 32'h4;
      @(negedge clk);
      exp_head += 32'h4; exp_req += 32'h4;
    end
    cache_valid = 1'b0;
    // Three entries must remain, still in order.
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) begin
        n_checks++; if (out_pc !== exp_head) begin n_fail++;
          $display("FAIL pushpop_drain got=%h exp=%h", out_pc, exp_head); end
        pops++; exp_head += 32'h4;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (pops != 3) begin n_fail++;
      $display("FAIL pushpop_count got=%0d exp=3", pops); end
  endtask

  task automatic test_redirect();
    do_reset();
    @(negedge clk);
    cache_valid = 1'b1; cache_inst = Addi; suggest_pc = 32'h4;
    @(negedge clk);
    should_reset = 1'b1; reset_pc = 32'h80; suggest_pc = 32'h8;
    @(negedge clk);
    should_reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || fetch_enable !== 1'b0) begin n_fail++;
      $display("FAIL redir_t1 v=%b fe=%b exp v=0 fe=0", out_valid, fetch_enable); end
    @(negedge clk);
    n_checks++; if (fetch_enable !== 1'b1 || cache_pc !== 32'h80 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_t2 fe=%b pc=%h v=%b exp fe=1 pc=80 v=0", fetch_enable, cache_pc,
               out_valid); end
    suggest_pc = 32'h84;
    @(negedge clk);
    cache_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || cache_pc !== 32'h84) begin
      n_fail++;
      $display("FAIL redir_resume v=%b head=%h req=%h exp v=1 head=80 req=84", out_valid,
               out_pc, cache_pc); end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    @(negedge clk);
    cache_valid = 1'b1; cache_inst = Addi; suggest_pc = 32'h4;
    @(negedge clk);
    rdy = 1'b0; out_ready = 1'b1; suggest_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      cache_valid = (i != 1);
      @(negedge clk);
      n_checks++; if (fetch_enable !== 1'b1 || cache_pc !== 32'h4 || out_valid !== 1'b1 ||
                      out_pc !== 32'h0) begin n_fail++;
        $display("FAIL stall_hold%0d fe=%b req=%h v=%b head=%h exp fe=1 req=4 v=1 head=0", i,
                 fetch_enable, cache_pc, out_valid, out_pc); end
    end
    rdy = 1'b1; out_ready = 1'b0; cache_valid = 1'b1; suggest_pc = 32'h8;
    @(negedge clk);
    cache_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (out_pc !== 32'h0 || cache_pc !== 32'h8) begin n_fail++;
      $display("FAIL stall_resume head=%h req=%h exp head=0 req=8", out_pc, cache_pc); end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_fail++;
      $display("FAIL stall_second v=%b head=%h exp v=1 head=4", out_valid, out_pc); end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [31:0] exp_pc = ResetPc;
    logic [31:0] tmp;
    logic        prev_free = 1'b0;
    int          ready_pct;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++;
        $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if (out_inst !== q[0].inst || out_pc !== q[0].pc ||
                        out_jump !== q[0].jump) begin n_fail++;
          $display("FAIL rnd_head cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, out_inst, out_pc,
                   out_jump, q[0].inst, q[0].pc, q[0].jump); end
      end
      if (fetch_enable === 1'b1) begin
        n_checks++; if (q.size() >= Depth || cache_pc !== exp_pc || predict_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL rnd_request cyc=%0d occ=%0d req=%h pred=%h exp req=%h", cyc, q.size(),
                   cache_pc, predict_pc, exp_pc); end
      end
      if (prev_free) begin
        n_checks++; if (fetch_enable !== 1'b1) begin n_fail++;
          $display("FAIL rnd_issue_latency cyc=%0d fe=%b exp=1", cyc, fetch_enable); end
      end
      // Alternate between draining and back-pressured phases.
      ready_pct    = ((cyc / 250) % 2 == 0) ? 85 : 20;
      rdy          = ($urandom_range(0, 15) != 0);
      should_reset = ($urandom_range(0, 79) == 0);
      tmp          = $urandom;
      reset_pc     = {tmp[31:2], 2'b00};
      out_ready    = ($urandom_range(0, 99) < ready_pct);
      cache_valid  = ($urandom_range(0, 2) != 0);
      tmp          = $urandom;
      cache_inst   = ($urandom_range(0, 3) == 0) ? {tmp[31:7], 7'h6F} : {tmp[31:7], 7'h13};
      suggest_jump = $urandom_range(0, 1);
      tmp          = $urandom;
      suggest_pc   = {tmp[31:2], 2'b00};
      #1;
      n_checks++; if (predict_inst !== cache_inst) begin n_fail++;
        $display("FAIL rnd_predict_inst cyc=%0d got=%h exp=%h", cyc, predict_inst, cache_inst);
      end
      // Reference update for the coming edge.
      prev_free = rdy && !should_reset && (fetch_enable === 1'b0) && (q.size() < Depth);
      if (rdy) begin
        if (should_reset) begin
          q.delete();
          exp_pc = reset_pc;
        end else begin
          if (q.size() != 0 && out_ready) void'(q.pop_front());
          if (fetch_enable === 1'b1 && cache_valid) begin
            e.inst = cache_inst;
            e.pc   = exp_pc;
            if (cache_inst[6:0] == 7'h6F) begin
              e.jump = 1'b1;
              exp_pc = exp_pc + jimm_model(cache_inst);
            end else begin
              e.jump = suggest_jump;
              exp_pc = suggest_pc;
            end
            q.push_back(e);
          end
        end
      end
    end
    rdy = 1'b1; should_reset = 1'b0; cache_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_jal();
    test_full();
    test_full_push_pop();
    test_redirect();
    test_rdy_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
